// File: rtl/spi_sl_regs_if.sv
// SPI pin bundle between an SPI master and spi_sl_regs.
// miso_oe drives the pad tristate enable for miso.
interface spi_sl_regs_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, miso_oe
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, miso_oe
  );
endinterface

// File: rtl/spi_sl_regs.sv
// Oversampling SPI slave with a register file.
// Read data is returned on miso within the same frame.
module spi_sl_regs #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 12,
  parameter int NREGS     = 64,
  parameter int FRAME_W   = 32,
  parameter int ADDR_LSB  = 8,
  parameter int DATA_LSB  = 16,
  parameter int CPOL_CPHA = 0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                    sys_clk,
  input  logic                    rstn,
  spi_sl_regs_if.slave            spi,
  output logic [NREGS*DATA_W-1:0] reg_q,
  output logic                    wr_stb,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic                    frame_err
);

  if (CPOL_CPHA != 0 && CPOL_CPHA != 3) begin : g_mode_chk
    $error("spi_sl_regs: CPOL_CPHA must be 0 or 3");
  end
  if (DATA_LSB < ADDR_LSB + ADDR_W + 1 ||
      DATA_LSB + DATA_W > FRAME_W) begin : g_frame_chk
    $error("spi_sl_regs: illegal frame layout");
  end
  if (NREGS < 1 || NREGS > 2**ADDR_W) begin : g_nregs_chk
    $error("spi_sl_regs: NREGS out of range");
  end

  localparam int CW = $clog2(FRAME_W + 1);
  localparam logic SCK_IDLE = (CPOL_CPHA == 3);
  localparam logic [CW-1:0] A_LO = CW'(ADDR_LSB);
  localparam logic [CW-1:0] A_HI = CW'(ADDR_LSB + ADDR_W);
  localparam logic [CW-1:0] D_LO = CW'(DATA_LSB);
  localparam logic [CW-1:0] D_HI = CW'(DATA_LSB + DATA_W);
  localparam logic [CW-1:0] F_END = CW'(FRAME_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  logic [1:0] sck_s;
  logic [1:0] cs_s;
  logic [1:0] mosi_s;
  logic       sck_q;
  logic [1:0] arm_v;
  logic       armed;
  logic       lead;

  // armed stays low until cs_n is seen high after reset, so a
  // frame already running when rstn rises is never picked up
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      sck_s  <= {2{SCK_IDLE}};
      sck_q  <= SCK_IDLE;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      arm_v  <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sck_s  <= {sck_s[0], spi.sclk};
      sck_q  <= sck_s[1];
      cs_s   <= {cs_s[0], spi.cs_n};
      mosi_s <= {mosi_s[0], spi.mosi};
      arm_v  <= {arm_v[0], 1'b1};
      armed  <= armed | (arm_v[1] & cs_s[1]);
    end
  end

  assign lead = SCK_IDLE ? (sck_q & ~sck_s[1])
                         : (sck_s[1] & ~sck_q);
  assign spi.miso_oe = ~cs_s[1];

  state_t              st;
  logic [CW-1:0]       bitcnt;
  logic [CW-1:0]       nxt;
  logic                rwb;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   data;
  logic [DATA_W-1:0]   tx;
  logic [DATA_W-1:0]   rd_val;
  logic                in_rng;
  logic                miso_r;

  assign nxt = bitcnt + 1'b1;
  assign in_rng = {1'b0, addr} < (ADDR_W + 1)'(NREGS);
  assign spi.miso = miso_r;

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (addr == ADDR_W'(k)) rd_val = reg_q[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      st        <= IDLE;
      bitcnt    <= '0;
      rwb       <= 1'b0;
      addr      <= '0;
      data      <= '0;
      tx        <= '0;
      miso_r    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      reg_q     <= {NREGS{RESET_VAL}};
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      unique case (st)
        IDLE: begin
          if (armed && !cs_s[1]) begin
            st     <= SHIFT;
            bitcnt <= '0;
            tx     <= '0;
            miso_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (bitcnt == F_END) begin
            st     <= DONE;
            miso_r <= 1'b0;
            if (!in_rng) begin
              frame_err <= 1'b1;
            end else if (!rwb) begin
              for (int k = 0; k < NREGS; k++) begin
                if (addr == ADDR_W'(k))
                  reg_q[k*DATA_W +: DATA_W] <= data;
              end
              wr_stb  <= 1'b1;
              wr_addr <= addr;
            end
          end else if (cs_s[1]) begin
            st        <= IDLE;
            miso_r    <= 1'b0;
            frame_err <= 1'b1;
          end else if (lead) begin
            bitcnt <= nxt;
            if (bitcnt == '0) rwb <= mosi_s[1];
            if (bitcnt >= A_LO && bitcnt < A_HI)
              addr <= {mosi_s[1], addr[ADDR_W-1:1]};
            if (bitcnt >= D_LO && bitcnt < D_HI)
              data <= {mosi_s[1], data[DATA_W-1:1]};
            // present the bit the master samples on its next edge
            if (nxt >= D_LO && nxt < D_HI) begin
              miso_r <= tx[0];
              tx     <= tx >> 1;
            end else begin
              miso_r <= 1'b0;
            end
          end else if (bitcnt == A_HI) begin
            tx <= rwb ? rd_val : '0;
          end
        end
        DONE: begin
          if (cs_s[1]) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sl_regs.sv
// Bench for spi_sl_regs: three instances (mode 0 / 64 regs,
// mode 0 / 16 regs, mode 3 / 64 regs) on shared sclk and mosi.
module tb_spi_sl_regs;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [2:0] cs = 3'b111;

  logic [767:0] rq0, rq2;
  logic [191:0] rq1;
  logic [5:0]   wa0, wa1, wa2;
  logic [2:0]   ws, fe;

  int n_tests = 0;
  int n_fail = 0;
  int wc[3];
  int ec[3];
  bit [11:0] mdl[3][64];
  int nr[3] = '{64, 16, 64};

  always #5 clk = ~clk;

  spi_sl_regs_if if0 ();
  spi_sl_regs_if if1 ();
  spi_sl_regs_if if2 ();

  assign if0.sclk = sclk;
  assign if0.mosi = mosi;
  assign if0.cs_n = cs[0];
  assign if1.sclk = sclk;
  assign if1.mosi = mosi;
  assign if1.cs_n = cs[1];
  assign if2.sclk = sclk;
  assign if2.mosi = mosi;
  assign if2.cs_n = cs[2];

  spi_sl_regs dut0 (
    .sys_clk(clk), .rstn(rstn), .spi(if0),
    .reg_q(rq0), .wr_stb(ws[0]), .wr_addr(wa0),
    .frame_err(fe[0])
  );

  spi_sl_regs #(.NREGS(16)) dut1 (
    .sys_clk(clk), .rstn(rstn), .spi(if1),
    .reg_q(rq1), .wr_stb(ws[1]), .wr_addr(wa1),
    .frame_err(fe[1])
  );

  spi_sl_regs #(.CPOL_CPHA(3)) dut2 (
    .sys_clk(clk), .rstn(rstn), .spi(if2),
    .reg_q(rq2), .wr_stb(ws[2]), .wr_addr(wa2),
    .frame_err(fe[2])
  );

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ws[k] === 1'b1) wc[k] <= wc[k] + 1;
      if (fe[k] === 1'b1) ec[k] <= ec[k] + 1;
    end
  end

  function automatic logic mi_of(input int d);
    case (d)
      0: return if0.miso;
      1: return if1.miso;
      default: return if2.miso;
    endcase
  endfunction

  function automatic logic oe_of(input int d);
    case (d)
      0: return if0.miso_oe;
      1: return if1.miso_oe;
      default: return if2.miso_oe;
    endcase
  endfunction

  function automatic logic [767:0] rq_of(input int d);
    logic [767:0] r;
    case (d)
      0: r = rq0;
      1: r = {576'b0, rq1};
      default: r = rq2;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] wa_of(input int d);
    case (d)
      0: return wa0;
      1: return wa1;
      default: return wa2;
    endcase
  endfunction

  function automatic logic [767:0] exp_rq(input int d);
    logic [767:0] r;
    r = '0;
    for (int k = 0; k < nr[d]; k++) r[k*12 +: 12] = mdl[d][k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [767:0] obs,
                     input logic [767:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI transfer; nbits < 32 aborts, rst_at >= 0 pulses rstn.
  task automatic frame(input int d, input bit rwb, input int addr,
                       input int data, input int nbits,
                       input int rst_at, output logic [31:0] mi,
                       output bit oe_ok);
    logic [31:0] f;
    logic [11:0] dv;
    logic [5:0]  av;
    logic        ld;
    dv = data[11:0];
    av = addr[5:0];
    f = {4'b0, dv, 2'b0, av, 7'b0, rwb};
    ld = (d == 2) ? 1'b0 : 1'b1;
    mi = '0;
    oe_ok = 1'b1;
    @(negedge clk);
    sclk = ~ld;
    #20;
    cs[d] = 1'b0;
    #20;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rstn = 1'b0;
        #15;
        rstn = 1'b1;
        #5;
      end
      mosi = f[i];
      #20;
      mi[i] = mi_of(d);
      if (oe_of(d) !== 1'b1) oe_ok = 1'b0;
      sclk = ld;
      #20;
      sclk = ~ld;
    end
    #20;
    cs[d] = 1'b1;
    #60;
    if (oe_of(d) !== 1'b0) oe_ok = 1'b0;
  endtask

  task automatic run(input int d, input bit rwb, input int addr,
                     input int data, input int nbits,
                     input string tag);
    int w0, e0, ewc, eec;
    logic [31:0] mi, em;
    bit oe_ok, inr;
    w0 = wc[d];
    e0 = ec[d];
    frame(d, rwb, addr, data, nbits, -1, mi, oe_ok);
    inr = addr < nr[d];
    ewc = 0;
    eec = 0;
    em = '0;
    if (nbits < 32) begin
      eec = 1;
    end else begin
      if (!inr) eec = 1;
      else if (!rwb) begin
        mdl[d][addr] = data[11:0];
        ewc = 1;
      end
      if (rwb && inr) em = {4'b0, mdl[d][addr], 16'b0};
    end
    chk({tag, ".wr_stb"}, wc[d] - w0, ewc);
    chk({tag, ".frame_err"}, ec[d] - e0, eec);
    chk({tag, ".reg_q"}, rq_of(d), exp_rq(d));
    chk({tag, ".miso_oe"}, oe_ok, 1);
    if (rwb && nbits == 32) chk({tag, ".miso"}, mi, em);
    if (ewc == 1) chk({tag, ".wr_addr"}, wa_of(d), addr);
  endtask

  initial begin
    logic [31:0] mi;
    bit oe_ok;
    int w0;
    #3;
    rstn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d.reg_q", d), rq_of(d), exp_rq(d));
      chk($sformatf("rst%0d.wr_addr", d), wa_of(d), 0);
      chk($sformatf("rst%0d.miso", d), mi_of(d), 0);
      chk($sformatf("rst%0d.miso_oe", d), oe_of(d), 0);
    end
    chk("rst.wr_stb", ws, 0);
    chk("rst.frame_err", fe, 0);
    #40;
    @(negedge clk);
    rstn = 1'b1;
    #50;

    run(0, 1'b0, 12, 'hABC, 32, "t1");
    run(0, 1'b1, 12, 0, 32, "t2");
    run(0, 1'b0, 5, 'h123, 20, "t3");
    run(1, 1'b0, 40, 'h555, 32, "t4w");
    run(1, 1'b1, 40, 0, 32, "t4r");
    run(1, 1'b0, 9, 'h2A7, 32, "t4ok");
    run(1, 1'b1, 9, 0, 32, "t4okr");

    for (int i = 0; i < 20; i++) begin
      int a, nb;
      a = (i % 3 == 0) ? 12 : int'($urandom_range(0, 63));
      nb = ($urandom_range(0, 5) == 0) ?
           int'($urandom_range(1, 31)) : 32;
      run(0, 1'($urandom_range(0, 1)), a,
          int'($urandom_range(0, 4095)), nb,
          $sformatf("r0_%0d", i));
    end
    for (int i = 0; i < 12; i++) begin
      run(1, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 31)),
          int'($urandom_range(0, 4095)), 32,
          $sformatf("r1_%0d", i));
    end

    w0 = wc[0];
    frame(0, 1'b0, 7, 'h3C5, 32, 24, mi, oe_ok);
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 64; k++) mdl[d][k] = '0;
    chk("t5.wr_stb", wc[0] - w0, 0);
    for (int d = 0; d < 3; d++)
      chk($sformatf("t5.reg_q%0d", d), rq_of(d), exp_rq(d));
    run(0, 1'b0, 7, 'h3C5, 32, "t5b");
    run(0, 1'b1, 7, 0, 32, "t5c");

    run(2, 1'b0, 63, 'h7FF, 32, "t6w");
    run(2, 1'b1, 63, 0, 32, "t6r");
    for (int i = 0; i < 8; i++) begin
      run(2, 1'($urandom_range(0, 1)),
          int'($urandom_range(60, 63)),
          int'($urandom_range(0, 4095)), 32,
          $sformatf("r2_%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
